pipe_skid_stage: RTL and testbench



---
 rtl/pipe_skid_stage.sv | 172 +++++++++++++++++
 tb/tb_pipe_skid_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage register with a two-entry skid buffer, synchronous flush and optional
// performance counters enabled by defining PIPE_STAGE_PERF_EN.
module pipe_skid_stage #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [CTRL_W-1:0]   r_mainCtrl;
    logic [DATA_W-1:0]   r_mainData;
    logic [CTRL_W-1:0]   r_skidCtrl;
    logic [DATA_W-1:0]   r_skidData;

    logic w_mainValid;
    logic w_skidValid;
    logic w_inFire;
    logic w_outFire;
    logic w_loadMainIn;
    logic w_loadMainSkid;
    logic w_loadSkid;
    logic w_clearMainCtrl;
    logic w_clearSkidCtrl;

    // The state encoding is the occupancy, so both valid bits decode straight from the register.
    assign w_mainValid = (r_state != EMPTY);
    assign w_skidValid = (r_state == FULL);
    assign in_ready    = !w_skidValid;
    assign w_inFire    = in_valid && in_ready;
    assign w_outFire   = w_mainValid && out_ready;

    assign out_valid   = w_mainValid;
    assign out_ctrl    = r_mainCtrl;
    assign out_data    = r_mainData;
    assign occupancy   = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState     = r_state;
        w_loadMainIn    = 1'b0;
        w_loadMainSkid  = 1'b0;
        w_loadSkid      = 1'b0;
        w_clearMainCtrl = 1'b0;
        w_clearSkidCtrl = 1'b0;
        if (flush) begin
            w_nextState     = EMPTY;
            w_clearMainCtrl = 1'b1;
            w_clearSkidCtrl = 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_inFire) begin
                        w_nextState  = ONE;
                        w_loadMainIn = 1'b1;
                    end
                end
                ONE: begin
                    if (w_inFire && w_outFire) begin
                        w_loadMainIn = 1'b1;
                    end else if (w_inFire) begin
                        w_nextState = FULL;
                        w_loadSkid  = 1'b1;
                    end else if (w_outFire) begin
                        w_nextState     = EMPTY;
                        w_clearMainCtrl = 1'b1;
                    end
                end
                FULL: begin
                    if (w_outFire) begin
                        w_nextState     = ONE;
                        w_loadMainSkid  = 1'b1;
                        w_clearSkidCtrl = 1'b1;
                    end
                end
                default: begin
                    w_nextState = EMPTY;
                end
            endcase
        end
    end

    // Data fields only load on a transfer; control is cleared whenever its entry empties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mainCtrl <= '0;
            r_mainData <= '0;
        end else if (w_loadMainIn) begin
            r_mainCtrl <= in_ctrl;
            r_mainData <= in_data;
        end else if (w_loadMainSkid) begin
            r_mainCtrl <= r_skidCtrl;
            r_mainData <= r_skidData;
        end else if (w_clearMainCtrl) begin
            r_mainCtrl <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skidCtrl <= '0;
            r_skidData <= '0;
        end else if (w_loadSkid) begin
            r_skidCtrl <= in_ctrl;
            r_skidData <= in_data;
        end else if (w_clearSkidCtrl) begin
            r_skidCtrl <= '0;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;
    logic [1:0]       w_squashed;
    logic [CNT_W:0]   w_flushSum;

    // A beat leaving through out_fire during a flush was delivered, so it is not squashed.
    assign w_squashed = {1'b0, (w_mainValid && !out_ready)} + {1'b0, w_skidValid};
    assign w_flushSum = {1'b0, r_flushCnt} + {{(CNT_W-1){1'b0}}, w_squashed};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (w_mainValid && !out_ready && (r_stallCnt != {CNT_W{1'b1}})) begin
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            end
            if (flush) begin
                r_flushCnt <= w_flushSum[CNT_W] ? {CNT_W{1'b1}} : w_flushSum[CNT_W-1:0];
            end
        end
    end

    assign stall_cnt = r_stallCnt;
    assign flush_cnt = r_flushCnt;
`else
    // Counters are compiled out; the stage behaves identically without them.
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: a queue-based model checked every cycle plus directed
// literal expectations; counter checks are active when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_skid_stage;

    localparam int CW = 8;
    localparam int DW = 128;
    localparam int NW = 4;
    localparam int SAT = (1 << NW) - 1;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [NW-1:0] stall_cnt;
    logic [NW-1:0] flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         modelQ[$];
    logic [DW-1:0] modelMainData = '0;
    int            modelStall = 0;
    int            modelFlush = 0;

    pipe_skid_stage #(
        .CTRL_W(CW),
        .DATA_W(DW),
        .CNT_W (NW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Transaction-level model: a FIFO of at most two beats, updated on each rising edge.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                modelQ.delete();
                modelMainData = '0;
                modelStall    = 0;
                modelFlush    = 0;
            end else begin
                int  sz;
                bit  inFire;
                bit  outFire;
                sz      = modelQ.size();
                inFire  = in_valid && (sz < 2);
                outFire = (sz > 0) && out_ready;
                if (sz > 0 && !out_ready) modelStall = (modelStall < SAT) ? modelStall + 1 : SAT;
                if (flush) begin
                    modelFlush = modelFlush + sz - (outFire ? 1 : 0);
                    if (modelFlush > SAT) modelFlush = SAT;
                    modelQ.delete();
                end else begin
                    if (outFire) void'(modelQ.pop_front());
                    if (inFire) modelQ.push_back('{ctrl: in_ctrl, data: in_data});
                end
                if (modelQ.size() > 0) modelMainData = modelQ[0].data;
            end
        end
    end

    task automatic checkOutput();
        int sz;
        sz = modelQ.size();
        checkValue("out_valid", DW'(out_valid), DW'(sz > 0));
        checkValue("out_ctrl", DW'(out_ctrl), (sz > 0) ? DW'(modelQ[0].ctrl) : '0);
        checkValue("out_data", out_data, modelMainData);
        checkValue("in_ready", DW'(in_ready), DW'(sz < 2));
        checkValue("occupancy", DW'(occupancy), DW'(sz));
`ifdef PIPE_STAGE_PERF_EN
        checkValue("stall_cnt", DW'(stall_cnt), DW'(modelStall));
        checkValue("flush_cnt", DW'(flush_cnt), DW'(modelFlush));
`endif
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) checkOutput();
        end
    end

    task automatic applyStimulus(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checkValue("rst_out_valid", DW'(out_valid), '0);
        checkValue("rst_in_ready", DW'(in_ready), DW'(1));
        checkValue("rst_occupancy", DW'(occupancy), '0);
        checkValue("rst_out_data", out_data, '0);

        // Streaming at one beat per cycle.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, CW'(8'h10 + i), DW'(i), 1'b1, 1'b0);
            checkValue("stream_data", out_data, DW'(i));
            checkValue("stream_occ", DW'(occupancy), DW'(1));
            checkValue("stream_ready", DW'(in_ready), DW'(1));
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkValue("drain_valid", DW'(out_valid), '0);
        checkValue("drain_ctrl", DW'(out_ctrl), '0);
        checkValue("drain_data_kept", out_data, DW'(8));

        // Backpressure: A and B held, C waits upstream.
        applyStimulus(1'b1, 8'h0A, DW'(16'hA0A0), 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h0B, DW'(16'hB0B0), 1'b0, 1'b0);
        checkValue("bp_occ_full", DW'(occupancy), DW'(2));
        checkValue("bp_ready_low", DW'(in_ready), '0);
        applyStimulus(1'b1, 8'h0C, DW'(16'hC0C0), 1'b0, 1'b0);
        checkValue("bp_hold_a", out_data, DW'(16'hA0A0));
        applyStimulus(1'b1, 8'h0C, DW'(16'hC0C0), 1'b1, 1'b0);
        checkValue("bp_then_b", out_data, DW'(16'hB0B0));
        checkValue("bp_b_ctrl", DW'(out_ctrl), DW'(8'h0B));
        applyStimulus(1'b1, 8'h0C, DW'(16'hC0C0), 1'b1, 1'b0);
        checkValue("bp_then_c", out_data, DW'(16'hC0C0));
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkValue("bp_empty", DW'(occupancy), '0);

        // Flush while full, with a beat offered the same cycle.
        applyStimulus(1'b1, 8'hFF, DW'(16'h1111), 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hFF, DW'(16'h2222), 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hFF, DW'(16'h3333), 1'b0, 1'b1);
        checkValue("fl_valid", DW'(out_valid), '0);
        checkValue("fl_ctrl", DW'(out_ctrl), '0);
        checkValue("fl_occ", DW'(occupancy), '0);
        checkValue("fl_ready", DW'(in_ready), DW'(1));
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkValue("fl_dropped", DW'(out_valid), '0);
`ifdef PIPE_STAGE_PERF_EN
        checkValue("fl_cnt_two", DW'(flush_cnt), DW'(2));
`endif

        // Flush coinciding with out_fire in ONE.
        applyStimulus(1'b1, 8'h33, DW'(16'hE0E0), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
        checkValue("flfire_occ", DW'(occupancy), '0);
`ifdef PIPE_STAGE_PERF_EN
        checkValue("flfire_cnt", DW'(flush_cnt), DW'(2));
`endif

        // Long stall to saturate the stall counter.
        applyStimulus(1'b1, 8'h44, DW'(16'hF0F0), 1'b0, 1'b0);
        repeat (20) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkValue("stall_hold", out_data, DW'(16'hF0F0));
`ifdef PIPE_STAGE_PERF_EN
        checkValue("stall_sat", DW'(stall_cnt), DW'(SAT));
`endif

        // Asynchronous reset while full.
        applyStimulus(1'b1, 8'h5A, DW'(16'hAAAA), 1'b0, 1'b0);
        checkValue("pre_rst_occ", DW'(occupancy), DW'(2));
        #2 reset = 1'b1;
        #1;
        checkValue("arst_valid", DW'(out_valid), '0);
        checkValue("arst_ctrl", DW'(out_ctrl), '0);
        checkValue("arst_data", out_data, '0);
        checkValue("arst_ready", DW'(in_ready), DW'(1));
        checkValue("arst_occ", DW'(occupancy), '0);
        in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkValue("post_rst_occ", DW'(occupancy), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
